// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the registered, packet-aware stream crossbar.
package stream_xbar_pkg;

  localparam int unsigned ARB_RR      = 0;
  localparam int unsigned ARB_FIXED   = 1;
  localparam int unsigned MAX_BUS_W   = 256;
  localparam int unsigned MAX_SLICE_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Extract slice idx of width w from a packed per-source bus (zero-extended by the caller).
  function automatic logic [MAX_SLICE_W-1:0] slice_src(
    input logic [MAX_BUS_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          w
  );
    logic [MAX_BUS_W-1:0] shifted;
    shifted = bus >> (idx * w);
    return MAX_SLICE_W'(shifted);
  endfunction

endpackage

// File: rtl/stream_xbar_rr_arbiter.sv
// Per-master arbiter: picks a source in IDLE, then holds it until its last beat is accepted.
module xbar_rr_arbiter
  import stream_xbar_pkg::*;
#(
  parameter int unsigned S_COUNT  = 5,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned IW       = $clog2(S_COUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_COUNT-1:0] req,
  input  logic [S_COUNT-1:0] valid,
  input  logic [S_COUNT-1:0] last,
  input  logic               adv,
  output logic [S_COUNT-1:0] grant_c,
  output logic [IW-1:0]      grant_idx_c,
  output logic               busy,
  output logic [IW-1:0]      lock_idx
);

  arb_state_e    state_q;
  logic [IW-1:0] ptr_q;
  logic          found_c;
  logic          accept_c;
  int unsigned   cand_c;

  // Winner selection: locked source when BUSY, else first requester from the search base.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found_c     = 1'b0;
    accept_c    = 1'b0;
    cand_c      = 0;
    if (state_q == BUSY) begin
      grant_idx_c = lock_idx;
      found_c     = 1'b1;
    end else begin
      for (int unsigned k = 0; k < S_COUNT; k++) begin
        cand_c = ((ARB_MODE == ARB_RR) ? 32'(ptr_q) : 32'd0) + k;
        if (cand_c >= S_COUNT) cand_c = cand_c - S_COUNT;
        if (!found_c && req[IW'(cand_c)]) begin
          found_c     = 1'b1;
          grant_idx_c = IW'(cand_c);
        end
      end
    end
    grant_c[grant_idx_c] = found_c;
    accept_c = found_c && valid[grant_idx_c] && adv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      ptr_q    <= '0;
      lock_idx <= '0;
    end else if (accept_c) begin
      if (last[grant_idx_c]) begin
        state_q <= IDLE;
        busy    <= 1'b0;
        if (ARB_MODE == ARB_RR)
          ptr_q <= (grant_idx_c == IW'(S_COUNT - 1)) ? '0 : grant_idx_c + IW'(1);
      end else begin
        state_q  <= BUSY;
        busy     <= 1'b1;
        lock_idx <= grant_idx_c;
      end
    end
  end

endmodule

// File: rtl/stream_xbar_rr.sv
// Registered packet crossbar: S valid/ready sources to M masters, one output register per master.
module stream_xbar_rr
  import stream_xbar_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned S_DATA_COUNT = 5,
  parameter int unsigned M_DATA_COUNT = 3,
  parameter int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int unsigned T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1,
  parameter int unsigned ARB_MODE     = ARB_RR
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_i,
  input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  output logic [T_DATA_WIDTH*M_DATA_COUNT-1:0] m_data_o,
  output logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o,
  output logic [M_DATA_COUNT-1:0]              m_last_o,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i
);

  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] src_dest_c;
  logic [S_DATA_COUNT-1:0]                   locked_c;
  logic [S_DATA_COUNT-1:0]                   src_busy_c;
  logic [S_DATA_COUNT-1:0]                   bad_dest_c;
  logic [S_DATA_COUNT-1:0]                   drop_q;

  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req_c;
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] grant_c;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_idx_c;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] lock_idx;
  logic [M_DATA_COUNT-1:0]                   busy;
  logic [M_DATA_COUNT-1:0]                   adv_c;
  logic [M_DATA_COUNT-1:0]                   accept_c;

  logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_q;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] m_id_q;

  assign m_data_o = m_data_q;
  assign m_id_o   = m_id_q;

  // Sources already owned by a master or mid-drop may not open a new request.
  always_comb begin
    src_dest_c = '0;
    locked_c   = '0;
    src_busy_c = '0;
    bad_dest_c = '0;
    req_c      = '0;
    for (int unsigned i = 0; i < S_DATA_COUNT; i++) begin
      src_dest_c[i] = T_DEST_WIDTH'(slice_src(MAX_BUS_W'(s_dest_i), i, T_DEST_WIDTH));
      for (int unsigned j = 0; j < M_DATA_COUNT; j++)
        if (busy[j] && lock_idx[j] == T_ID___WIDTH'(i)) locked_c[i] = 1'b1;
      src_busy_c[i] = locked_c[i] | drop_q[i];
      bad_dest_c[i] = s_valid_i[i] && !src_busy_c[i] && (32'(src_dest_c[i]) >= M_DATA_COUNT);
      for (int unsigned j = 0; j < M_DATA_COUNT; j++)
        req_c[j][i] = s_valid_i[i] && !src_busy_c[i] && (32'(src_dest_c[i]) == j);
    end
  end

  always_comb begin
    adv_c = '0;
    for (int unsigned j = 0; j < M_DATA_COUNT; j++)
      adv_c[j] = !rst && (!m_valid_o[j] || m_ready_i[j]);
  end

  for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_arb
    xbar_rr_arbiter #(
      .S_COUNT (S_DATA_COUNT),
      .ARB_MODE(ARB_MODE),
      .IW      (T_ID___WIDTH)
    ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        (req_c[j]),
      .valid      (s_valid_i),
      .last       (s_last_i),
      .adv        (adv_c[j]),
      .grant_c    (grant_c[j]),
      .grant_idx_c(grant_idx_c[j]),
      .busy       (busy[j]),
      .lock_idx   (lock_idx[j])
    );
  end

  // Dropped packets are always accepted so the source drains through to its last beat.
  always_comb begin
    s_ready_o = '0;
    accept_c  = '0;
    for (int unsigned j = 0; j < M_DATA_COUNT; j++)
      accept_c[j] = adv_c[j] && |(grant_c[j] & s_valid_i);
    for (int unsigned i = 0; i < S_DATA_COUNT; i++) begin
      s_ready_o[i] = !rst && (drop_q[i] || bad_dest_c[i]);
      for (int unsigned j = 0; j < M_DATA_COUNT; j++)
        if (grant_c[j][i] && adv_c[j]) s_ready_o[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      for (int unsigned i = 0; i < S_DATA_COUNT; i++) begin
        if (drop_q[i]) begin
          if (s_valid_i[i] && s_last_i[i]) drop_q[i] <= 1'b0;
        end else if (bad_dest_c[i] && !s_last_i[i]) begin
          drop_q[i] <= 1'b1;
        end
      end
    end
  end

  // Output register per master; holds while stalled, empties after a handshake with no refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q  <= '0;
      m_id_q    <= '0;
      m_last_o  <= '0;
      m_valid_o <= '0;
    end else begin
      for (int unsigned j = 0; j < M_DATA_COUNT; j++) begin
        if (accept_c[j]) begin
          m_data_q[j]  <= T_DATA_WIDTH'(slice_src(MAX_BUS_W'(s_data_i), 32'(grant_idx_c[j]), T_DATA_WIDTH));
          m_id_q[j]    <= grant_idx_c[j];
          m_last_o[j]  <= s_last_i[grant_idx_c[j]];
          m_valid_o[j] <= 1'b1;
        end else if (m_ready_i[j]) begin
          m_valid_o[j] <= 1'b0;
        end
      end
    end
  end

endmodule
